// File: rtl/axis_result_streamer_pkg.sv
// Shared constants and types for the RES result streamer.
//   DATA_WIDTH : RES entry width
//   AXIS_WIDTH : stream data width (>= DATA_WIDTH)
//   DEPTH_BITS : RES address width
//   NUM_WORDS  : words per frame (2 .. 2**DEPTH_BITS)
package axis_res_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned AXIS_WIDTH = 32;
    localparam int unsigned DEPTH_BITS = 6;
    localparam int unsigned NUM_WORDS  = 64;

    // Zero padding prepended to each RES entry on the stream.
    localparam int unsigned ZEXT_WIDTH = AXIS_WIDTH - DATA_WIDTH;

    // Read counter needs one extra bit to hold NUM_WORDS (the "all issued" value).
    localparam int unsigned RD_CNT_W = DEPTH_BITS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    // One buffered stream word before zero extension.
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/axis_result_streamer_if.sv
// AXI4-Stream bundle for the result streamer.
//   TVALID/TDATA/TLAST : master -> slave
//   TREADY             : slave -> master
interface axis_result_streamer_if;
    import axis_res_pkg::*;

    logic                  TVALID;
    logic [AXIS_WIDTH-1:0] TDATA;
    logic                  TLAST;
    logic                  TREADY;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);

endinterface

// File: rtl/axis_result_streamer_res_skid_fifo.sv
// Two-entry FIFO of {last, data} buffering RES reads ahead of the stream.
//   ACLK, ARESET : clock, async active-high reset (clears to empty)
//   push, push_entry : write one entry
//   pop          : remove head (caller guarantees not empty)
//   empty, count, head : status and head entry
module res_skid_fifo
    import axis_res_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       push,
    input  res_entry_t push_entry,
    input  logic       pop,
    output logic       empty,
    output logic [1:0] count,
    output res_entry_t head
);

    res_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    // Storage clears too, so the stream data bus reads zero out of reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/axis_result_streamer.sv
// Streams the RES memory out as one AXI4-Stream frame per start pulse.
//   ACLK, ARESET         : clock, async active-high reset
//   start                : request one frame (ignored while busy)
//   busy, done           : frame in progress / one-cycle completion pulse
//   ram_ren, ram_raddr   : RES read port (1-cycle latency)
//   ram_rdata            : RES read data
//   m_axis               : stream master (TDATA zero-extended, TLAST on final word)
module axis_result_streamer
    import axis_res_pkg::*;
(
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ren,
    output logic [DEPTH_BITS-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    axis_result_streamer_if.master m_axis
);

    state_e                state;
    state_e                state_next;
    logic [RD_CNT_W-1:0]   rd_addr;
    logic                  rd_pending;
    logic                  rd_pending_last;
    logic                  issue;
    logic                  pop;
    logic [2:0]            cnt;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    res_entry_t            fifo_head;
    res_entry_t            push_entry;

    assign pop = !fifo_empty && m_axis.TREADY;

    // Words already buffered plus the read still in flight.
    assign cnt = 3'(fifo_count) + 3'(rd_pending);

    // Next-state, read issue and status decode.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                // A pop this cycle frees the slot the new read will land in.
                if ((rd_addr < RD_CNT_W'(NUM_WORDS)) &&
                    ((cnt < 3'd2) || ((cnt == 3'd2) && pop))) begin
                    issue = 1'b1;
                end
                if (pop && fifo_head.last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, read counter and in-flight read tracking.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state           <= IDLE;
            rd_addr         <= '0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
        end else begin
            state           <= state_next;
            rd_pending      <= issue;
            rd_pending_last <= issue && (rd_addr == RD_CNT_W'(NUM_WORDS - 1));
            if (state == DONE) begin
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + RD_CNT_W'(1);
            end
        end
    end

    assign ram_ren   = issue;
    assign ram_raddr = DEPTH_BITS'(rd_addr);

    assign push_entry.last = rd_pending_last;
    assign push_entry.data = ram_rdata;

    res_skid_fifo u_fifo (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .push       (rd_pending),
        .push_entry (push_entry),
        .pop        (pop),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    assign m_axis.TVALID = !fifo_empty;
    assign m_axis.TDATA  = {{ZEXT_WIDTH{1'b0}}, fifo_head.data};
    assign m_axis.TLAST  = fifo_head.last;

endmodule
